// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order word fetches,
// buffers {instr, pc} for decode, and flushes/discards stale responses on redirect.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] rq_mem    [DEPTH];

  logic issue, resp_acc, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both in-flight requests and buffered entries, so the buffer never overflows.
  assign imem_req_valid = !reset && !redirect &&
                          (({1'b0, inflight_q} + {1'b0, count_q}) < CREDITS);
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign if_valid       = !reset && !redirect && (count_q != '0);
  assign if_instr       = instr_mem[rd_ptr_q];
  assign if_pc          = pc_mem[rd_ptr_q];

  assign issue    = imem_req_valid && imem_req_ready;
  assign resp_acc = imem_resp_valid && (inflight_q != '0);
  assign pop      = if_valid && id_ready;
  assign push     = resp_acc && !redirect && (drop_q == '0);

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q - CW'(resp_acc);
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rq_wr_d    = rq_wr_q;
    rq_rd_d    = resp_acc ? ptr_inc(rq_rd_q) : rq_rd_q;
    if (redirect) begin
      // Every request still outstanding after this edge returns stale data.
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d   = inflight_q - CW'(resp_acc);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + XLEN'(4);
        rq_wr_d    = ptr_inc(rq_wr_q);
        inflight_d = inflight_q + CW'(1) - CW'(resp_acc);
      end
      if (resp_acc && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rq_wr_q    <= '0;
      rq_rd_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rq_wr_q    <= rq_wr_d;
      rq_rd_q    <= rq_rd_d;
    end
  end

  // Payload storage carries no reset; occupancy is governed by the control state above.
  always_ff @(posedge clk) begin
    if (issue) rq_mem[rq_wr_q] <= pc_q;
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]    <= rq_mem[rq_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency and an
// architectural scoreboard of the expected fetch/delivery PC streams.
module tb_fetch_unit;
  localparam int          XLEN     = 64;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid = 1'b0;
  logic [31:0]     imem_resp_data = '0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready = 1'b0;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, acc_cnt = 0, del_cnt = 0;
  bit          k_reset = 1'b1, k_redirect = 1'b0, k_ready = 1'b0, k_idr = 1'b0, k_spur = 1'b0;
  logic [63:0] k_rpc = '0;
  int          k_lat_min = 1, k_lat_max = 1;
  logic [63:0] exp_pc = RESET_PC, exp_req = RESET_PC;
  bit          obs_ifv, obs_reqv, delivered, served;
  logic [63:0] obs_pc, obs_addr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  // One clock cycle: drive inputs, check observed outputs against the model, advance the model.
  task automatic step();
    req_t r;
    @(negedge clk);
    reset           = k_reset;
    redirect        = k_redirect;
    redirect_pc     = k_rpc;
    imem_req_ready  = k_ready;
    id_ready        = k_idr;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    served          = 1'b0;
    if (!k_reset) begin
      if (memq.size() > 0) begin
        if (memq[0].due <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(memq[0].addr);
          served          = 1'b1;
        end
      end else if (k_spur) begin
        imem_resp_valid = 1'b1;
      end
    end
    #1;
    obs_ifv   = if_valid;
    obs_reqv  = imem_req_valid;
    obs_pc    = if_pc;
    obs_addr  = imem_req_addr;
    delivered = 1'b0;
    if (k_reset || k_redirect) begin
      check_eq("ifv_blocked", if_valid, 0);
      check_eq("req_blocked", imem_req_valid, 0);
    end else begin
      check_eq("credit_bound", memq.size() <= DEPTH, 1);
      if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req);
      if (if_valid && id_ready) begin
        check_eq("if_pc", if_pc, exp_pc);
        check_eq("if_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 64'd4;
        del_cnt++;
        delivered = 1'b1;
      end
    end
    if (k_reset) begin
      memq.delete();
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
      acc_cnt = 0;
      del_cnt = 0;
    end else begin
      if (served) void'(memq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + int'($urandom_range(k_lat_max, k_lat_min));
        memq.push_back(r);
        exp_req = exp_req + 64'd4;
        acc_cnt++;
      end
      if (k_redirect) begin
        exp_pc  = k_rpc & ~64'h3;
        exp_req = exp_pc;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    k_reset = 1'b1; k_redirect = 1'b0; k_spur = 1'b0;
    step(); step();
    k_reset = 1'b0;
  endtask

  task automatic wait_deliver(input string tag, input int maxc, input logic [63:0] want);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (delivered) begin
        got = 1'b1;
        check_eq(tag, obs_pc, want);
      end
    end
    if (!got) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_mode(input bit rdy, input bit idr, input int lmin, input int lmax);
    k_ready = rdy; k_idr = idr; k_lat_min = lmin; k_lat_max = lmax;
  endtask

  initial begin
    // Zero-wait memory: first instruction two cycles after the first request.
    set_mode(1, 1, 1, 1);
    do_reset();
    step(); check_eq("t1_c0_ifv", obs_ifv, 0);
    step(); check_eq("t1_c1_ifv", obs_ifv, 0);
    step(); check_eq("t1_first_ifv", obs_ifv, 1); check_eq("t1_first_pc", obs_pc, RESET_PC);
    for (int i = 0; i < 20 && del_cnt < 4; i++) step();
    check_eq("t1_delivered4", del_cnt >= 4, 1);

    // Decode stall: buffer fills, fetch stops at DEPTH requests, then drains in order.
    set_mode(1, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 10 && !obs_ifv; i++) step();
    for (int i = 0; i < 10; i++) step();
    check_eq("t2_held_ifv", obs_ifv, 1);
    check_eq("t2_held_pc", obs_pc, RESET_PC);
    check_eq("t2_req_count", acc_cnt, DEPTH);
    check_eq("t2_req_low", obs_reqv, 0);
    k_idr = 1'b1;
    for (int i = 0; i < 20 && del_cnt < 3; i++) step();
    check_eq("t2_released", del_cnt >= 3, 1);

    // Redirect with two requests outstanding: both responses must be dropped.
    set_mode(1, 1, 3, 3);
    do_reset();
    k_redirect = 1'b1; k_rpc = 64'h10; step(); k_redirect = 1'b0;
    step(); step();
    check_eq("t3_two_inflight", memq.size(), 2);
    k_redirect = 1'b1; k_rpc = 64'h103; step(); k_redirect = 1'b0;
    k_lat_min = 1; k_lat_max = 1;
    wait_deliver("t3_first_pc", 20, 64'h100);
    wait_deliver("t3_second_pc", 20, 64'h104);

    // Redirect in the same cycle a response arrives while one entry is buffered.
    set_mode(1, 0, 1, 1);
    do_reset();
    step(); step();
    k_redirect = 1'b1; k_rpc = 64'h200; step(); k_redirect = 1'b0;
    check_eq("t4_resp_in_redirect", served, 1);
    check_eq("t4_ifv_redirect", obs_ifv, 0);
    k_idr = 1'b1;
    wait_deliver("t4_first_pc", 20, 64'h200);

    // Memory back-pressure: request held stable at 0x8, accepted exactly once.
    set_mode(1, 1, 1, 1);
    do_reset();
    step(); step();
    k_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check_eq("t5_req_held", obs_reqv, 1);
    check_eq("t5_addr_held", obs_addr, 64'h8);
    check_eq("t5_acc_before", acc_cnt, 2);
    k_ready = 1'b1; step();
    check_eq("t5_acc_once", acc_cnt, 3);
    wait_deliver("t5_next_pc", 20, 64'h8);

    // PC wrap at the top of the address space.
    set_mode(1, 1, 1, 1);
    do_reset();
    k_redirect = 1'b1; k_rpc = 64'hFFFF_FFFF_FFFF_FFFC; step(); k_redirect = 1'b0;
    wait_deliver("t6_top_pc", 20, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_deliver("t6_wrap_pc", 20, 64'h0);

    // Reset with two in flight; stray responses afterwards are ignored.
    set_mode(1, 1, 3, 3);
    k_redirect = 1'b1; k_rpc = 64'h40; step(); k_redirect = 1'b0;
    step(); step();
    check_eq("t6_two_inflight", memq.size(), 2);
    k_reset = 1'b1; step(); step(); k_reset = 1'b0;
    set_mode(0, 1, 1, 1);
    k_spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_spurious_ifv", obs_ifv, 0);
    end
    k_spur = 1'b0; k_ready = 1'b1;
    wait_deliver("t6_reset_pc", 20, RESET_PC);

    // Randomized traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      k_ready    = ($urandom_range(0, 3) != 0);
      k_idr      = ($urandom_range(0, 3) != 0);
      k_lat_min  = 1;
      k_lat_max  = 3;
      k_redirect = ($urandom_range(0, 24) == 0);
      k_rpc      = $urandom_range(0, 1) ? {$urandom, $urandom}
                                        : 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      k_reset    = ($urandom_range(0, 299) == 0);
      k_spur     = ($urandom_range(0, 7) == 0);
      step();
    end
    k_reset = 1'b0; k_redirect = 1'b0; k_spur = 1'b0;
    set_mode(1, 1, 1, 1);
    for (int i = 0; i < 10; i++) step();
    check_eq("rand_progress", del_cnt > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
